muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_div_step.sv | 29 ++
 rtl/muldiv_sequencer.sv | 167 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings, state type and helpers for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int          DIV_CYCLES = 32;
    localparam int          CNT_W      = 5;
    localparam logic [31:0] LO_DIV0    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_e;

    // Magnitude of an operand; unsigned ops pass through untouched.
    function automatic logic [31:0] op_mag(input logic [31:0] v, input logic is_signed);
        logic [31:0] m;
        if (is_signed && v[31]) begin
            m = 32'd0 - v;
        end else begin
            m = v;
        end
        return m;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module muldiv_div_step
    import muldiv_pkg::*;
(
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quo_next
);

    logic [32:0] shifted_s;
    logic [33:0] diff_s;
    logic        fits_s;

    // Remainder stays below the divisor, so both outcomes fit back into 32 bits.
    always_comb begin
        shifted_s = {rem, quo[31]};
        diff_s    = {1'b0, shifted_s} - {2'b00, divisor};
        fits_s    = ~diff_s[33];
        if (fits_s) begin
            rem_next = diff_s[31:0];
        end else begin
            rem_next = shifted_s[31:0];
        end
        quo_next = {quo[30:0], fits_s};
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage multi-cycle MULT/DIV controller owning the architectural HI/LO registers.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    input  logic            rd_req,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       op_r;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [31:0]      rem_r;
    logic [31:0]      quo_r;
    logic [31:0]      dvs_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic             busy_r;
    logic             done_r;

    logic [31:0]        rem_next_s;
    logic [31:0]        quo_next_s;
    logic               signed_s;
    logic signed [65:0] a_ext_s;
    logic signed [65:0] b_ext_s;
    logic signed [65:0] prod_s;
    logic [31:0]        res_hi_s;
    logic [31:0]        res_lo_s;

    muldiv_div_step u_div_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvs_r),
        .rem_next (rem_next_s),
        .quo_next (quo_next_s)
    );

    // Final HI/LO values from the latched operands and the divider state.
    always_comb begin
        signed_s = ~op_r[0];
        a_ext_s  = 66'(signed'({signed_s & a_r[31], a_r}));
        b_ext_s  = 66'(signed'({signed_s & b_r[31], b_r}));
        prod_s   = a_ext_s * b_ext_s;
        if (!op_r[1]) begin
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end else if (b_r == 32'd0) begin
            res_hi_s = a_r;
            res_lo_s = LO_DIV0;
        end else begin
            // Quotient sign from the operand signs, remainder follows the dividend.
            res_lo_s = (signed_s && (a_r[31] ^ b_r[31])) ? (32'd0 - quo_r) : quo_r;
            res_hi_s = (signed_s && a_r[31]) ? (32'd0 - rem_r) : rem_r;
        end
    end

    // Sequencer FSM, iteration counter, divider datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= OP_MULT;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            rem_r   <= 32'd0;
            quo_r   <= 32'd0;
            dvs_r   <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r  <= {CNT_W{1'b0}};
                    done_r <= 1'b0;
                    if (start && !flush) begin
                        op_r    <= op;
                        a_r     <= a;
                        b_r     <= b;
                        rem_r   <= 32'd0;
                        quo_r   <= op_mag(a, ~op[0]);
                        dvs_r   <= op_mag(b, ~op[0]);
                        state_r <= op[1] ? DIV : MUL;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                        // A start squashed by flush still owns the slot, so MT writes stay dropped.
                        if (!start && hi_we) begin
                            hi_r <= wdata;
                        end
                        if (!start && lo_we) begin
                            lo_r <= wdata;
                        end
                    end
                end
                MUL: begin
                    if (flush) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else if (cnt_r == CNT_W'(MUL_LATENCY - 1)) begin
                        state_r <= FIN;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DIV: begin
                    if (flush) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else begin
                        rem_r <= rem_next_s;
                        quo_r <= quo_next_s;
                        if (cnt_r == CNT_W'(DIV_CYCLES - 1)) begin
                            state_r <= FIN;
                            done_r  <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    if (!flush) begin
                        hi_r <= res_hi_s;
                        lo_r <= res_lo_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign hi    = hi_r;
    assign lo    = lo_r;
    assign stall = busy_r & (start | rd_req | hi_we | lo_we);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer with hand-computed HI/LO results.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        rd_req;
    logic        flush;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    muldiv_sequencer #(.MUL_LATENCY(4), .XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .rd_req (rd_req),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, check busy/done/stall every busy cycle, then the HI/LO result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input int n_busy, input logic use_rd,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start = 1'b1; op = o; a = av; b = bv;
        step();
        start = 1'b0;
        rd_req = use_rd;
        #1;
        for (int k = 1; k <= n_busy; k++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_done"}, {31'd0, done}, {31'd0, (k == n_busy)});
            if (use_rd) chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
            step();
        end
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_end"}, {31'd0, done}, 32'd0);
        if (use_rd) chk({tag, "_stall_end"}, {31'd0, stall}, 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        rd_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0; rd_req = 1'b0; flush = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rd_req = 1'b1;
        #1;
        chk("idle_stall", {31'd0, stall}, 32'd0);
        rd_req = 1'b0;

        // MTHI in IDLE
        hi_we = 1'b1; wdata = 32'hCAFE_0000;
        step();
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'hCAFE_0000);
        chk("mthi_lo", lo, 32'd0);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3, 5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 33, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 2'b11, 32'd100, 32'd7, 33, 1'b0, 32'd2, 32'd14);
        run_op("divu_zero", 2'b11, 32'd7, 32'd0, 33, 1'b0, 32'd7, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0, 32'd0, 32'h8000_0000);
        run_op("div_zero_s", 2'b10, 32'hFFFF_FFF0, 32'd0, 33, 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

        // Flush mid-divide leaves HI/LO untouched
        hi_we = 1'b1; wdata = 32'h11;
        step();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        step();
        lo_we = 1'b0;
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
        step();
        start = 1'b0;
        for (int k = 1; k < 10; k++) step();
        chk("flush_busy_c10", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 30; k++) begin
            chk("flush_no_done", {31'd0, done}, 32'd0);
            step();
        end
        chk("flush_hi", hi, 32'h11);
        chk("flush_lo", lo, 32'h22);

        // flush together with start in IDLE: not accepted
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
        step();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);

        // Reset mid-operation clears HI/LO
        start = 1'b1; op = 2'b11; a = 32'd50; b = 32'd5;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);

        // start with lo_we: MT write dropped, op runs
        start = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_0000; op = 2'b01; a = 32'd5; b = 32'd6;
        step();
        start = 1'b0; lo_we = 1'b0;
        chk("stlo_busy", {31'd0, busy}, 32'd1);
        chk("stlo_lo_dropped", lo, 32'd0);
        for (int k = 1; k < 5; k++) step();
        chk("stlo_done", {31'd0, done}, 32'd1);
        step();
        chk("stlo_hi", hi, 32'd0);
        chk("stlo_lo", lo, 32'd30);

        // start while busy is ignored and stalls
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'hFFFF_FFFD;
        step();
        op = 2'b11; a = 32'd1; b = 32'd1;
        #1;
        chk("busy_start_stall", {31'd0, stall}, 32'd1);
        step();
        start = 1'b0; hi_we = 1'b1; wdata = 32'h5555_5555;
        #1;
        chk("busy_mthi_stall", {31'd0, stall}, 32'd1);
        step();
        hi_we = 1'b0;
        step();
        step();
        chk("busy_start_done", {31'd0, done}, 32'd1);
        step();
        chk("busy_start_busy", {31'd0, busy}, 32'd0);
        chk("busy_start_hi", hi, 32'hFFFF_FFFF);
        chk("busy_start_lo", lo, 32'hFFFF_FFEB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
